// File: rtl/aes_ks_pkg.sv
// Shared state encoding, round constants and byte-level helpers for the
// AES-128 inverse key-schedule engine.
package aes_ks_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_EMIT = 2'd2;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [3:0] AES_NR     = 4'd10;

  // S-box table stored with entry 0x00 in the most significant byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Undo xtime: an odd value must have come from a reduction by 0x1B.
  function automatic logic [7:0] rcon_inv(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] k, input logic [7:0] rc);
    logic [127:0] n;
    n = '0;
    for (int j = 0; j < 4; j++)
      n[8*j +: 8] = k[8*j +: 8] ^ sbox(k[8*(12 + ((j + 1) % 4)) +: 8]) ^ ((j == 0) ? rc : 8'h00);
    for (int c = 1; c < 4; c++)
      n[32*c +: 32] = k[32*c +: 32] ^ n[32*(c-1) +: 32];
    return n;
  endfunction

endpackage

// File: rtl/ks_inv_round.sv
// Combinational inverse AES-128 key-schedule round: recovers the previous
// round key from the newer one using four S-box lookups.
module ks_inv_round
  import aes_ks_pkg::*;
(
  input  logic [127:0] kin,
  input  logic [7:0]   RCON_in,
  output logic [127:0] kout
);

  logic [95:0] hi;
  logic [31:0] lo;

  genvar c, j;
  generate
    for (c = 1; c < 4; c++) begin : g_col
      assign hi[32*(c-1) +: 32] = kin[32*c +: 32] ^ kin[32*(c-1) +: 32];
    end
    // Column 0 needs the recovered column 3 (hi bytes 8..11), rotated by one.
    for (j = 0; j < 4; j++) begin : g_sb
      assign lo[8*j +: 8] = kin[8*j +: 8] ^ sbox(hi[8*(8 + ((j + 1) % 4)) +: 8])
                            ^ ((j == 0) ? RCON_in : 8'h00);
    end
  endgenerate

  assign kout = {hi, lo};

endmodule

// File: rtl/aes_ks_inv_iter.sv
// Iterative AES-128 inverse key schedule: takes K10 and emits K10..K0.
// Define AES_KS_INV_FWD_EN to also accept the master key K0 via in_is_k0.
//
// state   | meaning
// IDLE    | waiting for a key, in_ready high
// FWD     | rolling K0 forward to K10 (AES_KS_INV_FWD_EN only)
// EMIT    | presenting key_reg, stepping back one round per handshake
module aes_ks_inv_iter
  import aes_ks_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
`ifdef AES_KS_INV_FWD_EN
  input  logic         in_is_k0,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  state_t       state;
  logic [127:0] key_reg;
  logic [127:0] key_inv;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic         ready_q;
`ifdef AES_KS_INV_FWD_EN
  logic [3:0]   cnt;
`endif

  ks_inv_round u_inv (
    .kin     (key_reg),
    .RCON_in (rcon),
    .kout    (key_inv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      rcon    <= '0;
      round   <= '0;
      ready_q <= 1'b0;
`ifdef AES_KS_INV_FWD_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // ready_q gates acceptance so nothing is taken while in_ready reads 0
          if (in_valid && ready_q) begin
            key_reg <= in_key;
            ready_q <= 1'b0;
`ifdef AES_KS_INV_FWD_EN
            if (in_is_k0) begin
              rcon  <= RCON_FIRST;
              cnt   <= '0;
              state <= ST_FWD;
            end else
`endif
            begin
              rcon  <= RCON_LAST;
              round <= AES_NR;
              state <= ST_EMIT;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
`ifdef AES_KS_INV_FWD_EN
        ST_FWD: begin
          key_reg <= fwd_round(key_reg, rcon);
          cnt     <= cnt + 4'd1;
          if (cnt == AES_NR - 4'd1) begin
            rcon  <= RCON_LAST;
            round <= AES_NR;
            state <= ST_EMIT;
          end else begin
            rcon <= xtime(rcon);
          end
        end
`endif
        ST_EMIT: begin
          if (out_ready) begin
            if (round == 4'd0) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              key_reg <= key_inv;
              rcon    <= rcon_inv(rcon);
              round   <= round - 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state == ST_EMIT);
  assign out_key   = key_reg;
  assign out_round = round;
  assign out_last  = (state == ST_EMIT) && (round == 4'd0);

endmodule

// File: tb/tb_aes_ks_inv_iter.sv
// Scoreboard bench for aes_ks_inv_iter; reference model is a word-level
// AES-128 key expansion run forward or backward with a GF(2^8)-derived S-box.
module tb_aes_ks_inv_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
`ifdef AES_KS_INV_FWD_EN
  logic         in_is_k0 = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  always #5 clk = ~clk;

  aes_ks_inv_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
`ifdef AES_KS_INV_FWD_EN
    .in_is_k0  (in_is_k0),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_hs_cyc = -10;
  bit           bp = 1'b0;
  logic [7:0]   sb_tab [0:255];
  logic [7:0]   rc_tab [0:10];
  logic [31:0]  w      [0:43];
  logic [127:0] rk     [0:10];

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] x);
    logic [31:0] r;
    r = {x[7:0], x[31:8]};
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb_tab[r[8*i +: 8]];
    return r;
  endfunction

  task automatic fill_from_k0(input logic [127:0] k0);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {24'h0, rc_tab[i/4]};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  task automatic fill_from_k10(input logic [127:0] k10);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[40+i] = k10[32*i +: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if ((i + 4) % 4 == 0) t = sub_rot(t) ^ {24'h0, rc_tab[(i+4)/4]};
      w[i] = w[i+4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  task automatic push_seq();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.key = rk[r];
      e.round = 4'(r);
      e.last = (r == 0);
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold under stall.
  logic         stall_prev = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_round;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk(out_valid === 1'b1, "hold valid", 128'(out_valid), 128'd1);
        chk(out_key === prev_key, "hold key", out_key, prev_key);
        chk(out_round === prev_round, "hold round", 128'(out_round), 128'(prev_round));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected output", 128'(out_round), 128'd0);
        end else begin
          e = sb.pop_front();
          chk(out_key === e.key, "key", out_key, e.key);
          chk(out_round === e.round, "round", 128'(out_round), 128'(e.round));
          chk(out_last === e.last, "last", 128'(out_last), 128'(e.last));
          if (e.round != 4'd0)
            chk(dut.rcon === rc_tab[e.round], "rcon", 128'(dut.rcon), 128'(rc_tab[e.round]));
          if (out_last) last_hs_cyc = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_key = out_key;
      prev_round = out_round;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) break;
    end
    if (i == 100) chk(1'b0, "ready timeout", 128'(in_ready), 128'd1);
  endtask

  task automatic load(input logic [127:0] k, input bit k0);
    int z;
    wait_ready();
    in_key = k;
    in_valid = 1'b1;
`ifdef AES_KS_INV_FWD_EN
    in_is_k0 = k0;
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!k0) begin
      @(negedge clk);
      #1;
      chk(out_valid === 1'b1, "first latency", 128'(out_valid), 128'd1);
    end else begin
      z = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) z++;
      end
      chk(z == 0, "fwd quiet", 128'(z), 128'd0);
      @(negedge clk);
      #1;
      chk(out_valid === 1'b1, "fwd latency", 128'(out_valid), 128'd1);
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, "drain timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
  endtask

  logic [127:0] K10_V, K9_V, K1_V, K0_V;

  task automatic push_vectors();
    fill_from_k10(K10_V);
    rk[9] = K9_V;
    rk[1] = K1_V;
    rk[0] = K0_V;
    push_seq();
  endtask

  initial begin
    int n;
    logic [127:0] ka, kb;
    K10_V = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    K9_V  = bswap(128'hac7766f319fadc2128d12941575c006e);
    K1_V  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
    K0_V  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));
    begin
      int rc;
      rc = 1;
      rc_tab[0] = 8'h00;
      for (int r = 1; r <= 10; r++) begin
        rc_tab[r] = 8'(rc);
        rc = rc << 1;
        if (rc > 255) rc = rc ^ 'h11b;
      end
    end

    // reset state
    repeat (3) @(negedge clk);
    chk(out_valid === 1'b0, "rst out_valid", 128'(out_valid), 128'd0);
    chk(in_ready === 1'b0, "rst in_ready", 128'(in_ready), 128'd0);
    chk(out_key === '0, "rst out_key", out_key, 128'd0);
    chk(out_round === 4'd0 && out_last === 1'b0, "rst round/last", 128'({out_round, out_last}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready === 1'b1, "ready after release", 128'(in_ready), 128'd1);

    // known vector, no backpressure, 11 back-to-back outputs
    push_vectors();
    load(K10_V, 1'b0);
    #1;
    drain(n);
    chk(n == 11, "consecutive cycles", 128'(n), 128'd11);

    // same vector with random backpressure
    bp = 1'b1;
    push_vectors();
    load(K10_V, 1'b0);
    drain(n);

    // random keys under backpressure
    for (int t = 0; t < 5; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      fill_from_k10(ka);
      push_seq();
      load(ka, 1'b0);
      drain(n);
    end
    bp = 1'b0;

    // all-zero K10
    fill_from_k10('0);
    push_seq();
    load('0, 1'b0);
    drain(n);

`ifdef AES_KS_INV_FWD_EN
    fill_from_k0(K0_V);
    rk[10] = K10_V;
    push_seq();
    load(K0_V, 1'b1);
    drain(n);
    bp = 1'b1;
    for (int t = 0; t < 2; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      fill_from_k0(ka);
      push_seq();
      load(ka, 1'b1);
      drain(n);
    end
    bp = 1'b0;
    in_is_k0 = 1'b0;
`endif

    // in_valid held through EMIT: second key accepted right after K0
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    fill_from_k10(ka);
    push_seq();
    fill_from_k10(kb);
    push_seq();
    wait_ready();
    in_key = ka;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_key = kb;
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        #1;
        if (in_ready) break;
      end
      chk(i < 100, "ready after last", 128'(in_ready), 128'd1);
    end
    chk(cyc == last_hs_cyc + 1, "ready timing", 128'(cyc), 128'(last_hs_cyc + 1));
    chk(sb.size() == 11, "held valid ignored", 128'(sb.size()), 128'd11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk(out_valid === 1'b1 && out_round === 4'd10, "second accept", 128'({out_valid, out_round}), 128'h1a);
    drain(n);

    // reset in the middle of a sequence
    fill_from_k10(K10_V);
    push_seq();
    load(K10_V, 1'b0);
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        if (out_valid && out_round == 4'd5) break;
        @(negedge clk);
        #1;
      end
      chk(i < 50, "reach round 5", 128'(out_round), 128'd5);
    end
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    chk(out_valid === 1'b0 && out_last === 1'b0 && in_ready === 1'b0, "midrst flags",
        128'({out_valid, out_last, in_ready}), 128'd0);
    chk(out_key === '0 && out_round === 4'd0, "midrst data", out_key, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk(in_ready === 1'b1, "midrst release", 128'(in_ready), 128'd1);
    ka = {$urandom, $urandom, $urandom, $urandom};
    fill_from_k10(ka);
    push_seq();
    load(ka, 1'b0);
    drain(n);

    repeat (3) @(negedge clk);
    chk(sb.size() == 0, "scoreboard empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_ks_inv_iter.md
# aes_ks_inv_iter

Iterative AES-128 inverse key-schedule engine for the decryption datapath. It accepts a round-10 key and emits the round keys K10, K9, …, K0, one per output handshake. Each step rewinds the key by one schedule round in a single cycle. It sits between key storage and the inverse-cipher round logic, which consumes keys in reverse order.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `in_valid` in 1: `in_key` valid.
- `in_ready` out 1: engine idle and able to accept a key.
- `in_key` in 128: starting key. Byte i = `in_key[8i +: 8]`; column c = bytes 4c..4c+3.
- `in_is_k0` in 1: present only with `AES_KS_INV_FWD_EN`. 1 = `in_key` is the master key K0.
- `out_valid` out 1: `out_key` valid.
- `out_ready` in 1: consumer accepts `out_key`.
- `out_key` out 128: current round key, same byte order as `in_key`.
- `out_round` out 4: round index of `out_key`, 10 down to 0.
- `out_last` out 1: high with `out_round`==0.

## Operation
- States: IDLE, FWD (macro only), EMIT.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: key_reg<=`in_key`, rcon<=0x36, round<=10, go to EMIT.
  - With the macro and `in_is_k0`=1: rcon<=0x01, cnt<=0, go to FWD instead.
- FWD
  - Each cycle: key_reg<=fwd_round(key_reg, rcon); rcon<=xtime(rcon); cnt++.
  - After the 10th step, the registers hold round=10, rcon=0x36; go to EMIT.
  - `in_ready`=0 and `out_valid`=0 throughout.
- EMIT
  - `out_valid`=1; `out_key`=key_reg; `out_round`=round.
  - Without `out_ready`, all outputs hold stable.
  - On handshake with round==0: go to IDLE.
  - On handshake otherwise: key_reg<=inv_round(key_reg, rcon); rcon<=rcon_inv(rcon); round--.
- inv_round(k), with k the newer key:
  - p[4c+j]=k[4c+j]^k[4(c-1)+j] for c=1..3, j=0..3.
  - p[j]=k[j]^SB(p[12+((j+1) mod 4)]) for j=0..3, with rcon additionally XORed into j=0 only.
- rcon_inv(r) = r>>1 if r[0]==0, else (r^0x1B)>>1|0x80. Yields 0x36→0x1B→0x80→…→0x01.
- fwd_round is the standard forward schedule round. It uses the same byte mapping: RotWord takes byte 13 into position 0.
- Reset (`rst_n`=0 at a `clk` edge), including mid-sequence:
  - State goes to IDLE; the pending sequence is discarded.
  - `out_valid`=0, `out_key`=0, `out_round`=0, `out_last`=0.
  - `in_ready`=0 while reset is asserted, 1 from the first cycle after release.
- `in_valid` outside IDLE is ignored; no queuing.

## Timing
- Input handshake at edge t gives `out_valid` with K10 from cycle t+1. With FWD: from t+11.
- With `out_ready` held at 1, K10..K0 appear on 11 consecutive cycles.
- After the K0 handshake, `in_ready`=1 on the next cycle. A new key can be accepted 1 cycle after the last output.
- All outputs are registered or decoded from state only; there is no combinational path from `in_*` or `out_ready` to outputs.
- Inverse step critical path: one XOR layer, one S-box, two XORs.

## Configuration
- `AES_KS_INV_FWD_EN` defined:
  - `in_is_k0` port and the FWD state exist.
  - A forward round instance and the xtime rcon update are compiled in.
  - The master key is accepted directly.
- `AES_KS_INV_FWD_EN` undefined: no `in_is_k0` port, no FWD state; `in_key` is always K10.

## Structure
- Package `aes_ks_pkg`:
  - State enum.
  - RCON_FIRST=0x01, RCON_LAST=0x36, AES_NR=10.
  - xtime and rcon_inv functions.
- Sub-module `ks_inv_round`: combinational inv_round with 4 unmasked S-box instances, mirroring the forward round interface (`kin`, `kout`, `RCON_in`).
- The top holds the FSM, key_reg, rcon, round and handshake logic.

## Test plan
In all vectors below, the byte string is listed byte 0 first.
- Load K10=d014f9a8c9ee2589e13f0cc8b6630ca6, `out_ready`=1:
  - Next 11 cycles: `out_round` 10..0.
  - K9=ac7766f319fadc2128d12941575c006e.
  - K1=a0fafe1788542cb123a339392a6c7605.
  - K0=2b7e151628aed2a6abf7158809cf4f3c with `out_last`=1.
- Backpressure: toggle `out_ready` randomly.
  - `out_key` and `out_round` stable while `out_valid`&&!`out_ready`.
  - Sequence identical to the first scenario.
- Macro on, `in_is_k0`=1, key 2b7e…4f3c:
  - `out_valid` rises 11 cycles after acceptance with K10=d014…0ca6.
  - Remaining sequence as in the first scenario.
- `in_valid` held high during EMIT: ignored. After `out_last` handshake, `in_ready`=1 the next cycle and the new key is accepted.
- `rst_n`=0 while `out_round`=5: next cycle all outputs 0. After release, `in_ready`=1 and a fresh load restarts at round 10.
- All-zero K10: K9 equals the software model's inverse-round output. The rcon sequence checked internally is 36,1B,80,40,20,10,08,04,02,01.
